// File: rtl/vc_arbiter.sv
// vc_arbiter: picks at most one eligible VC head per cycle, pops it and pushes it to D0/D1 a cycle
// later. Define ARB_ROUND_ROBIN_EN for burst-limited round-robin; default is strict VC0 priority.
module vc_arbiter #(
  parameter int unsigned DATA_W   = 6,
  parameter int unsigned DEST_BIT = 4,
  parameter int unsigned BURST    = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              vc0_empty,
  input  logic              vc1_empty,
  input  logic [DATA_W-1:0] vc0_data,
  input  logic [DATA_W-1:0] vc1_data,
  input  logic              d0_pause,
  input  logic              d1_pause,
  output logic              vc0_pop,
  output logic              vc1_pop,
  output logic [DATA_W-1:0] d_data_out,
  output logic              d0_push,
  output logic              d1_push,
  output logic              idle_out,
  output logic [7:0]        grant_cnt_vc0,
  output logic [7:0]        grant_cnt_vc1
);

  if (BURST == 0 || BURST > 15) begin : g_bad_burst
    $error("vc_arbiter: BURST must be in 1..15");
  end
  if (DEST_BIT >= DATA_W) begin : g_bad_dest
    $error("vc_arbiter: DEST_BIT must index into the data word");
  end

  typedef enum logic [1:0] {StIdle, StServeVc0, StServeVc1} state_e;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                idle_q, idle_d;
  logic [7:0]          cnt0_q, cnt0_d;
  logic [7:0]          cnt1_q, cnt1_d;

  logic                vc0_elig, vc1_elig;
  logic                grant0, grant1;
  logic                pop_any;
  logic [DATA_W-1:0]   grant_word;

  // A head is eligible only if the destination it targets can take it; each VC is judged alone.
  assign vc0_elig = ~vc0_empty & ~(vc0_data[DEST_BIT] ? d1_pause : d0_pause);
  assign vc1_elig = ~vc1_empty & ~(vc1_data[DEST_BIT] ? d1_pause : d0_pause);

`ifdef ARB_ROUND_ROBIN_EN
  localparam logic [3:0] BurstLim = 4'(BURST);

  logic       last_grant_q, last_grant_d;  // 0: VC0, 1: VC1
  logic [3:0] burst_q, burst_d;
  logic       keep_vc;

  // A zero burst count (after reset) means no streak yet, so the other VC wins.
  assign keep_vc = (burst_q != 4'd0) && (burst_q < BurstLim);

  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (vc0_elig && vc1_elig) begin
      if (keep_vc) begin
        grant0 = ~last_grant_q;
        grant1 = last_grant_q;
      end else begin
        grant0 = last_grant_q;
        grant1 = ~last_grant_q;
      end
    end else begin
      grant0 = vc0_elig;
      grant1 = vc1_elig;
    end
  end

  always_comb begin
    last_grant_d = last_grant_q;
    burst_d      = burst_q;
    if (pop_any) begin
      last_grant_d = vc1_pop;
      if ((vc1_pop != last_grant_q) || (burst_q == 4'd0)) begin
        burst_d = 4'd1;
      end else if (burst_q != 4'hf) begin
        burst_d = burst_q + 4'd1;
      end
    end
  end
`else
  always_comb begin
    grant0 = vc0_elig;
    grant1 = vc1_elig & ~vc0_elig;
  end
`endif

  assign vc0_pop = grant0 & ~reset;
  assign vc1_pop = grant1 & ~reset;
  assign pop_any = vc0_pop | vc1_pop;

  always_comb begin
    state_d = StIdle;
    if (vc0_pop) begin
      state_d = StServeVc0;
    end else if (vc1_pop) begin
      state_d = StServeVc1;
    end
    grant_word = vc1_pop ? vc1_data : vc0_data;
    data_d     = pop_any ? grant_word : data_q;
    idle_d     = vc0_empty & vc1_empty & ~pop_any;
    cnt0_d     = (vc0_pop && (cnt0_q != 8'hff)) ? cnt0_q + 8'd1 : cnt0_q;
    cnt1_d     = (vc1_pop && (cnt1_q != 8'hff)) ? cnt1_q + 8'd1 : cnt1_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      data_q       <= '0;
      idle_q       <= 1'b1;
      cnt0_q       <= '0;
      cnt1_q       <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      last_grant_q <= 1'b1;
      burst_q      <= '0;
`endif
    end else begin
      state_q      <= state_d;
      data_q       <= data_d;
      idle_q       <= idle_d;
      cnt0_q       <= cnt0_d;
      cnt1_q       <= cnt1_d;
`ifdef ARB_ROUND_ROBIN_EN
      last_grant_q <= last_grant_d;
      burst_q      <= burst_d;
`endif
    end
  end

  // A serve state means a pop happened last cycle, so its word is in data_q right now.
  assign d_data_out    = data_q;
  assign d0_push       = (state_q != StIdle) & ~data_q[DEST_BIT];
  assign d1_push       = (state_q != StIdle) & data_q[DEST_BIT];
  assign idle_out      = idle_q;
  assign grant_cnt_vc0 = cnt0_q;
  assign grant_cnt_vc1 = cnt1_q;

endmodule

// File: tb/tb_vc_arbiter.sv
// tb_vc_arbiter: randomized self-checking bench for vc_arbiter; VC FIFOs are queues and the
// expected behaviour comes from a transaction-level model of the arbitration rules.
`timescale 1ns/1ps
module tb_vc_arbiter;
  localparam int DATA_W   = 6;
  localparam int DEST_BIT = 4;
  localparam int BURST    = 4;
  localparam int VW       = DATA_W + 21;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              vc0_empty, vc1_empty, d0_pause, d1_pause;
  logic [DATA_W-1:0] vc0_data, vc1_data, d_data_out;
  logic              vc0_pop, vc1_pop, d0_push, d1_push, idle_out;
  logic [7:0]        grant_cnt_vc0, grant_cnt_vc1;

  always #5 clk = ~clk;

  vc_arbiter #(.DATA_W(DATA_W), .DEST_BIT(DEST_BIT), .BURST(BURST)) dut (
    .clk(clk), .reset(reset),
    .vc0_empty(vc0_empty), .vc1_empty(vc1_empty),
    .vc0_data(vc0_data), .vc1_data(vc1_data),
    .d0_pause(d0_pause), .d1_pause(d1_pause),
    .vc0_pop(vc0_pop), .vc1_pop(vc1_pop),
    .d_data_out(d_data_out), .d0_push(d0_push), .d1_push(d1_push),
    .idle_out(idle_out), .grant_cnt_vc0(grant_cnt_vc0), .grant_cnt_vc1(grant_cnt_vc1)
  );

  int errors = 0;
  int checks = 0;

  logic [DATA_W-1:0] q0[$];
  logic [DATA_W-1:0] q1[$];
  logic p0 = 1'b0, p1 = 1'b0;

  // Model: expected registered outputs currently visible, plus expected pops for this cycle.
  logic [DATA_W-1:0] m_data = '0;
  logic m_push0 = 1'b0, m_push1 = 1'b0, m_idle = 1'b1;
  int   m_cnt0 = 0, m_cnt1 = 0, m_last = 1, m_streak = 0;
  logic e_pop0 = 1'b0, e_pop1 = 1'b0;

  logic [VW-1:0] obs;
  assign obs = {vc0_pop, vc1_pop, d0_push, d1_push, idle_out, d_data_out,
                grant_cnt_vc0, grant_cnt_vc1};

  function automatic logic [VW-1:0] expv();
    return {e_pop0, e_pop1, m_push0, m_push1, m_idle, m_data, 8'(m_cnt0), 8'(m_cnt1)};
  endfunction

  // Drive the FIFO heads and pauses, then work out which VC should be granted this cycle.
  task automatic settle();
    logic el0, el1;
    int   w;
    vc0_empty = (q0.size() == 0);
    vc1_empty = (q1.size() == 0);
    vc0_data  = (q0.size() != 0) ? q0[0] : '0;
    vc1_data  = (q1.size() != 0) ? q1[0] : '0;
    d0_pause  = p0;
    d1_pause  = p1;
    #1;
    el0 = (q0.size() != 0) && !(q0[0][DEST_BIT] ? p1 : p0);
    el1 = (q1.size() != 0) && !(q1[0][DEST_BIT] ? p1 : p0);
    e_pop0 = 1'b0;
    e_pop1 = 1'b0;
    if (!reset) begin
`ifdef ARB_ROUND_ROBIN_EN
      if (el0 && el1) begin
        w = (m_streak > 0 && m_streak < BURST) ? m_last : 1 - m_last;
        e_pop0 = (w == 0);
        e_pop1 = (w == 1);
      end else begin
        e_pop0 = el0;
        e_pop1 = el1;
      end
`else
      w = 0;
      e_pop0 = el0;
      e_pop1 = el1 && !el0;
`endif
    end
  endtask

  // Advance one clock and move the model forward by the transaction expected this cycle.
  task automatic tick();
    logic [DATA_W-1:0] w;
    bit both_empty;
    int g;
    both_empty = (q0.size() == 0) && (q1.size() == 0);
    @(posedge clk);
    if (reset) begin
      m_data = '0; m_push0 = 0; m_push1 = 0; m_idle = 1;
      m_cnt0 = 0; m_cnt1 = 0; m_last = 1; m_streak = 0;
    end else begin
      m_push0 = 0;
      m_push1 = 0;
      m_idle  = both_empty && !(e_pop0 || e_pop1);
      if (e_pop0 || e_pop1) begin
        g = e_pop1 ? 1 : 0;
        w = (g == 1) ? q1.pop_front() : q0.pop_front();
        m_data  = w;
        m_push0 = !w[DEST_BIT];
        m_push1 = w[DEST_BIT];
        if (g == 0 && m_cnt0 < 255) m_cnt0++;
        if (g == 1 && m_cnt1 < 255) m_cnt1++;
        m_streak = (g == m_last && m_streak > 0) ? ((m_streak < 15) ? m_streak + 1 : 15) : 1;
        m_last = g;
      end
    end
    #1;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    settle();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    q0 = '{6'h01, 6'h12};
    q1 = '{6'h03, 6'h14};
    reset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      settle();
      checks++;
      if ({vc0_pop, vc1_pop} !== 2'b00) begin
        errors++;
        $display("FAIL reset_pops cycle %0d: got %b expected 00", c, {vc0_pop, vc1_pop});
      end
      tick();
    end
    settle();
    checks++;
    if (obs !== expv()) begin
      errors++;
      $display("FAIL reset_values: got %h expected %h", obs, expv());
    end
    checks++;
    if (idle_out !== 1'b1 || grant_cnt_vc0 !== 8'd0 || grant_cnt_vc1 !== 8'd0) begin
      errors++;
      $display("FAIL reset_idle_cnt: got idle=%b cnt0=%0d cnt1=%0d expected 1 0 0",
               idle_out, grant_cnt_vc0, grant_cnt_vc1);
    end
    reset = 1'b0;
    q0.delete();
    q1.delete();
  endtask

  task automatic test_vc0_stream();
    int pops = 0;
    for (int i = 1; i <= 5; i++) q0.push_back(6'(i));
    for (int c = 0; c < 8; c++) begin
      settle();
      checks++;
      if (obs !== expv()) begin
        errors++;
        $display("FAIL vc0_stream cycle %0d: got %h expected %h", c, obs, expv());
      end
      if (vc0_pop) pops++;
      tick();
    end
    settle();
    checks++;
    if (pops != 5 || grant_cnt_vc0 !== 8'd5 || idle_out !== 1'b1) begin
      errors++;
      $display("FAIL vc0_stream_totals: got pops=%0d cnt0=%0d idle=%b expected 5 5 1",
               pops, grant_cnt_vc0, idle_out);
    end
  endtask

  task automatic test_hol_bypass();
    int  paused_vc0_pops = 0;
    bit  saw_d1 = 0;
    q0 = '{6'h10};
    q1 = '{6'h02};
    p1 = 1'b1;
    for (int c = 0; c < 8; c++) begin
      if (c == 4) p1 = 1'b0;
      settle();
      checks++;
      if (obs !== expv()) begin
        errors++;
        $display("FAIL hol_bypass cycle %0d: got %h expected %h", c, obs, expv());
      end
      if (c < 4 && vc0_pop) paused_vc0_pops++;
      if (d1_push && d_data_out == 6'h10) saw_d1 = 1;
      tick();
    end
    checks++;
    if (paused_vc0_pops != 0 || !saw_d1) begin
      errors++;
      $display("FAIL hol_bypass_summary: got vc0_pops_paused=%0d d1_push_0x10=%0d expected 0 1",
               paused_vc0_pops, saw_d1);
    end
  endtask

  task automatic test_arbitration();
    int order[$];
    int expg;
    pulse_reset();
    for (int i = 0; i < 8; i++) begin
      q0.push_back(6'($urandom_range(0, 63)));
      q1.push_back(6'($urandom_range(0, 63)));
    end
    for (int c = 0; c < 24; c++) begin
      settle();
      checks++;
      if (obs !== expv()) begin
        errors++;
        $display("FAIL arbitration cycle %0d: got %h expected %h", c, obs, expv());
      end
      if (vc0_pop) order.push_back(0);
      if (vc1_pop) order.push_back(1);
      tick();
    end
    checks++;
    if (order.size() != 16) begin
      errors++;
      $display("FAIL arbitration_count: got %0d grants expected 16", order.size());
    end
    for (int i = 0; i < order.size() && i < 16; i++) begin
`ifdef ARB_ROUND_ROBIN_EN
      expg = (i / BURST) % 2;
`else
      expg = (i < 8) ? 0 : 1;
`endif
      checks++;
      if (order[i] != expg) begin
        errors++;
        $display("FAIL arbitration_order grant %0d: got vc%0d expected vc%0d", i, order[i], expg);
      end
    end
  endtask

  task automatic test_random();
    int budget = 600;
    for (int i = 0; i < 40; i++) begin
      q0.push_back(6'($urandom_range(0, 63)));
      q1.push_back(6'($urandom_range(0, 63)));
    end
    while ((q0.size() != 0 || q1.size() != 0) && budget > 0) begin
      p0 = ($urandom_range(0, 3) == 0);
      p1 = ($urandom_range(0, 3) == 0);
      settle();
      checks++;
      if (obs !== expv()) begin
        errors++;
        $display("FAIL random cycle %0d: got %h expected %h", 600 - budget, obs, expv());
      end
      tick();
      budget--;
    end
    p0 = 1'b0;
    p1 = 1'b0;
    checks++;
    if (budget == 0) begin
      errors++;
      $display("FAIL random_drain: got %0d words left expected 0", q0.size() + q1.size());
    end
  endtask

  task automatic test_saturation();
    int budget = 1500;
    int pops = 0;
    for (int i = 0; i < 300; i++) q1.push_back(6'($urandom_range(0, 63)));
    while (q1.size() != 0 && budget > 0) begin
      p0 = ($urandom_range(0, 9) == 0);
      p1 = ($urandom_range(0, 9) == 0);
      settle();
      checks++;
      if (obs !== expv()) begin
        errors++;
        $display("FAIL saturation cycle %0d: got %h expected %h", 1500 - budget, obs, expv());
      end
      if (vc1_pop) pops++;
      tick();
      budget--;
    end
    p0 = 1'b0;
    p1 = 1'b0;
    settle();
    checks++;
    if (pops != 300 || grant_cnt_vc1 !== 8'd255) begin
      errors++;
      $display("FAIL saturation_total: got pops=%0d cnt1=%0d expected 300 255", pops, grant_cnt_vc1);
    end
  endtask

  task automatic test_reset_in_flight();
    pulse_reset();
    q0 = '{6'h05};
    settle();
    checks++;
    if (vc0_pop !== 1'b1) begin
      errors++;
      $display("FAIL inflight_pop: got %b expected 1", vc0_pop);
    end
    tick();
    reset = 1'b1;
    settle();
    checks++;
    if (d0_push !== 1'b1 || d_data_out !== 6'h05) begin
      errors++;
      $display("FAIL inflight_push: got push=%b data=%h expected 1 05", d0_push, d_data_out);
    end
    tick();
    reset = 1'b0;
    settle();
    checks++;
    if ({d0_push, d1_push} !== 2'b00 || d_data_out !== '0) begin
      errors++;
      $display("FAIL inflight_discard: got push=%b%b data=%h expected 00 00",
               d0_push, d1_push, d_data_out);
    end
    checks++;
    if (obs !== expv()) begin
      errors++;
      $display("FAIL inflight_state: got %h expected %h", obs, expv());
    end
  endtask

  initial begin
    test_reset();
    test_vc0_stream();
    test_hol_bypass();
    test_arbitration();
    test_random();
    test_saturation();
    test_reset_in_flight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
